muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, beside the ALU. It receives the same forwarded operands as the ALU and executes MIPS MULT/MULTU/DIV/DIVU into architectural HI/LO registers. Those registers feed the EX result mux for MFHI/MFLO. While an operation runs it asserts busy, and the hazard unit stalls the pipeline on that signal.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// MUL: radix-2 shift-add, DIV: restoring shift-subtract, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// MUL   | shift-add iterations on magnitudes
// DIV   | shift-subtract iterations on magnitudes
// FIX   | apply result signs, write HI/LO, pulse done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_flag;

    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and the per-iteration add / subtract terms.
    always_comb begin
        signed_op = op[0];
        a_abs     = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
        b_abs     = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
        mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod      = {acc_hi[WIDTH-1:0], acc_lo};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush aborts any non-idle state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (op[1] && (op_b == '0)) state_nxt = FIX;
                    else if (op[1])            state_nxt = DIV;
                    else                       state_nxt = MUL;
                end
            end
            MUL, DIV: begin
                if (flush)          state_nxt = IDLE;
                else if (cnt == '0) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: operand latch, iterations, result fix-up and MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_flag    <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            is_div   <= op[1];
                            neg_q    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_r    <= signed_op & op_a[WIDTH-1];
                            dbz_flag <= op[1] && (op_b == '0);
                            cnt      <= CNT_W'(WIDTH - 1);
                            acc_hi   <= '0;
                            if (op[1]) begin
                                acc_lo <= a_abs;
                                opnd   <= b_abs;
                            end else begin
                                acc_lo <= b_abs;
                                opnd   <= a_abs;
                            end
                        end
                    end else begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                MUL: begin
                    acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt - 1'b1;
                end
                DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= dbz_flag;
                        if (!dbz_flag) begin
                            if (is_div) begin
                                lo <= neg_q ? (~acc_lo + 1'b1) : acc_lo;
                                hi <= neg_r ? (~acc_hi[WIDTH-1:0] + 1'b1) : acc_hi[WIDTH-1:0];
                            end else begin
                                {hi, lo} <= neg_q ? (~prod + 1'b1) : prod;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected values.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op (start high for one cycle), wait for done with a bound,
    // then check latency, flags, HI/LO and that done lasts a single cycle.
    // intr re-asserts start mid-run; wr_too raises hi_we alongside start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input logic edbz, input logic intr, input logic wr_too);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        if (wr_too) begin hi_we = 1'b1; wr_data = 32'hABCD; end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            if (intr && n == 4) begin
                start = 1'b1; op = 2'b00; op_a = 32'h3; op_b = 32'h3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(elat));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    task automatic mt(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        hi_we = whi; lo_we = wlo; wr_data = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        int n;
        int dcnt;
        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // Reset mid-MULT after preloading HI.
        mt(1'b1, 1'b1, 32'h55);
        check("mt_pre_hi", 64'(hi), 64'h55);
        @(negedge clk);
        start = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (done) dcnt++; end
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin @(negedge clk); if (done) dcnt++; end
        rst = 1'b0;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) dcnt++; end
        check("midrst_no_done", 64'(dcnt), 64'd0);

        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0, 1'b0, 1'b0);
        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0, 1'b0, 1'b0);
        run_op("mult_mix", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, 1'b0, 1'b0, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 1'b0, 1'b0);
        run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 1'b0, 1'b0);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0, 1'b0, 1'b0);

        // Divide by zero leaves preloaded HI/LO intact.
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check("mt_hi", 64'(hi), 64'h11);
        check("mt_lo", 64'(lo), 64'h22);
        run_op("div0", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1'b1, 1'b0, 1'b0);
        run_op("divu0", 2'b10, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1'b1, 1'b0, 1'b0);

        // Flush mid-DIVU.
        @(negedge clk);
        start = 1'b1; op = 2'b10; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) dcnt++; end
        check("flush_no_done", 64'(dcnt), 64'd0);
        check("flush_hi", 64'(hi), 64'h11);
        check("flush_lo", 64'(lo), 64'h22);

        // Flush together with start in IDLE suppresses the start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);

        // MTHI while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b00; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        hi_we = 1'b1; wr_data = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0;
        check("busy_mthi_hi", 64'(hi), 64'h11);
        n = 0;
        while (!done && n < 60) begin @(negedge clk); n++; end
        check("busy_mthi_done", 64'(done), 64'd1);
        check("busy_mthi_res_hi", 64'(hi), 64'd0);
        check("busy_mthi_res_lo", 64'(lo), 64'd42);

        mt(1'b1, 1'b0, 32'hABCD);
        check("idle_mthi", 64'(hi), 64'hABCD);
        check("idle_mthi_lo", 64'(lo), 64'd42);

        run_op("we_with_start", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0, 1'b0, 1'b1);
        run_op("start_ignored", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
